// File: rtl/lsu_mem_if.sv
// Data-memory bus between the load/store unit (master) and data memory (slave).
// Carries the req/gnt request phase and the rvalid read-response phase.
interface lsu_mem_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        input  mem_gnt, mem_rvalid, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wstrb, mem_wdata,
        output mem_gnt, mem_rvalid, mem_rdata
    );
endinterface

// File: rtl/load_store_unit.sv
// RV32I load/store unit: lane steering, strobes, load extension, alignment checks, req/gnt/rvalid.
// Define LSU_TIMEOUT_EN to add a REQ/WAIT watchdog that aborts with fault cause 11.
module load_store_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic [31:0] rdata,
    output logic        fault,
    output logic [1:0]  fault_cause,
    lsu_mem_if.master   mem
);

    typedef enum logic [2:0] {StIdle, StReq, StWait, StResp, StFault} state_e;

    localparam logic [1:0] CauseMisalign = 2'b01;
    localparam logic [1:0] CauseFunct    = 2'b10;
    localparam logic [1:0] CauseTimeout  = 2'b11;

    state_e      state_q, state_d;
    logic        is_store_q, is_store_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [1:0]  cause_q, cause_d;

    logic        illegal_in, misalign_in, timeout;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_ext;

    // Decode of the not-yet-latched request, used only when start is taken in IDLE.
    always_comb begin
        if (is_store) begin
            illegal_in = funct3[2] | (funct3[1:0] == 2'b11);
        end else begin
            illegal_in = (funct3 == 3'b011) | (funct3[2:1] == 2'b11);
        end
        misalign_in = ((funct3[1:0] == 2'b01) & addr[0]) |
                      ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
    end

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) < 8) ? 8 :
                                   $clog2(TIMEOUT_CYCLES + 1);
    logic [CntW-1:0] cnt_q, cnt_d;

    assign timeout = (cnt_q == CntW'(TIMEOUT_CYCLES));

    // Restarts from zero whenever REQ or WAIT is freshly entered.
    always_comb begin
        cnt_d = '0;
        if ((state_q == state_d) && ((state_q == StReq) || (state_q == StWait))) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = (illegal_in | misalign_in) ? StFault : StReq;
                end
            end
            StReq: begin
                if (mem.mem_gnt) begin
                    state_d = is_store_q ? StResp : StWait;
                end else if (timeout) begin
                    state_d = StFault;
                end
            end
            StWait: begin
                if (mem.mem_rvalid) begin
                    state_d = StResp;
                end else if (timeout) begin
                    state_d = StFault;
                end
            end
            StResp:  state_d = StIdle;
            StFault: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        unique case (addr_q[1:0])
            2'b00:   load_byte = mem.mem_rdata[7:0];
            2'b01:   load_byte = mem.mem_rdata[15:8];
            2'b10:   load_byte = mem.mem_rdata[23:16];
            default: load_byte = mem.mem_rdata[31:24];
        endcase
        load_half = addr_q[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
        unique case (funct3_q[1:0])
            2'b00:   load_ext = {{24{~funct3_q[2] & load_byte[7]}}, load_byte};
            2'b01:   load_ext = {{16{~funct3_q[2] & load_half[15]}}, load_half};
            default: load_ext = mem.mem_rdata;
        endcase
    end

    always_comb begin
        is_store_d = is_store_q;
        funct3_d   = funct3_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        cause_d    = cause_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    is_store_d = is_store;
                    funct3_d   = funct3;
                    addr_d     = addr;
                    wdata_d    = wdata;
                    cause_d    = illegal_in ? CauseFunct : CauseMisalign;
                end
            end
            StReq: begin
                if (!mem.mem_gnt && timeout) begin
                    cause_d = CauseTimeout;
                end
            end
            StWait: begin
                if (mem.mem_rvalid) begin
                    rdata_d = load_ext;
                end else if (timeout) begin
                    cause_d = CauseTimeout;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_store_q <= 1'b0;
            funct3_q   <= 3'b000;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            cause_q    <= 2'b00;
        end else begin
            is_store_q <= is_store_d;
            funct3_q   <= funct3_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            cause_q    <= cause_d;
        end
    end

    always_comb begin
        busy          = (state_q != StIdle);
        done          = (state_q == StResp) || (state_q == StFault);
        fault         = (state_q == StFault);
        fault_cause   = fault ? cause_q : 2'b00;
        rdata         = rdata_q;
        mem.mem_req   = (state_q == StReq);
        mem.mem_we    = mem.mem_req & is_store_q;
        mem.mem_addr  = {addr_q[31:2], 2'b00};
        mem.mem_wstrb = 4'b0000;
        mem.mem_wdata = wdata_q;
        unique case (funct3_q[1:0])
            2'b00:   mem.mem_wdata = {4{wdata_q[7:0]}};
            2'b01:   mem.mem_wdata = {2{wdata_q[15:0]}};
            default: mem.mem_wdata = wdata_q;
        endcase
        if (mem.mem_we) begin
            unique case (funct3_q[1:0])
                2'b00:   mem.mem_wstrb = 4'b0001 << addr_q[1:0];
                2'b01:   mem.mem_wstrb = 4'b0011 << addr_q[1:0];
                default: mem.mem_wstrb = 4'b1111;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed cases plus randomized accesses
// checked against a byte-level reference model of RV32I load/store semantics.
module tb_load_store_unit;

    localparam int unsigned TO = 255;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, is_store;
    logic [2:0]  funct3;
    logic [31:0] addr, wdata;
    logic        busy, done, fault;
    logic [31:0] rdata;
    logic [1:0]  fault_cause;

    int errors = 0;
    int checks = 0;
    bit [31:0] last_rdata = 32'h0;

    lsu_mem_if mem_bus ();

    load_store_unit #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store), .funct3(funct3),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
        .fault(fault), .fault_cause(fault_cause), .mem(mem_bus)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic bit [1:0] m_cause(bit st, bit [2:0] f3, bit [31:0] a);
        bit legal;
        int unsigned nbytes;
        if (st) legal = (f3 <= 3'd2);
        else    legal = (f3 != 3'd3) && (f3 != 3'd6) && (f3 != 3'd7);
        if (!legal) return 2'd2;
        nbytes = 1 << f3[1:0];
        if ((a % nbytes) != 0) return 2'd1;
        return 2'd0;
    endfunction

    function automatic bit [3:0] m_strb(bit [2:0] f3, bit [31:0] a);
        int unsigned nbytes = 1 << f3[1:0];
        return 4'(((1 << nbytes) - 1) << (a % 4));
    endfunction

    function automatic bit [31:0] m_wdata(bit [2:0] f3, bit [31:0] wd);
        int unsigned nbytes = 1 << f3[1:0];
        bit [31:0] v;
        for (int i = 0; i < 4; i++) v[8*i +: 8] = 8'(wd >> (8 * (i % nbytes)));
        return v;
    endfunction

    function automatic bit [31:0] m_load(bit [2:0] f3, bit [31:0] a, bit [31:0] w);
        int unsigned nbytes = 1 << f3[1:0];
        longint unsigned mask, v;
        if (nbytes == 4) return w;
        mask = (64'd1 << (8 * nbytes)) - 1;
        v = (longint'(w) >> (8 * (a % 4))) & mask;
        if (!f3[2] && v >= (mask + 1) / 2) v = v + (64'hFFFF_FFFF - mask);
        return 32'(v);
    endfunction

    // ---------------- driver / memory responder ----------------
    task automatic do_access(
        input bit st, input bit [2:0] f3, input bit [31:0] a, input bit [31:0] wd,
        input int gnt_dly, input int rv_dly, input bit [31:0] rword, input bit noise,
        output int done_k, output bit flt, output bit [1:0] cause, output bit [31:0] rd,
        output int req_cnt, output bit [31:0] r_addr, output bit [3:0] r_strb,
        output bit [31:0] r_wdata, output bit r_we, output bit req_stable,
        output bit quiet_ok, output bit busy_ok, output bit busy_after);
        int granted_at = -1;
        bit got_done = 0;
        done_k = -1; flt = 0; cause = 0; rd = 0; req_cnt = 0;
        r_addr = 0; r_strb = 0; r_wdata = 0; r_we = 0;
        req_stable = 1; quiet_ok = 1; busy_ok = (busy === 1'b0);
        start = 1; is_store = st; funct3 = f3; addr = a; wdata = wd;
        for (int k = 1; k <= 2000 && !got_done; k++) begin
            @(posedge clk); #1;
            if (noise) begin
                start = 1; is_store = 1'($urandom); funct3 = 3'($urandom);
                addr = $urandom; wdata = $urandom;
            end else start = 0;
            mem_bus.mem_gnt = 0; mem_bus.mem_rvalid = 0; mem_bus.mem_rdata = $urandom;
            if (busy !== 1'b1) busy_ok = 0;
            if (mem_bus.mem_req === 1'b1) begin
                if (req_cnt == 0) begin
                    r_addr = mem_bus.mem_addr; r_strb = mem_bus.mem_wstrb;
                    r_wdata = mem_bus.mem_wdata; r_we = mem_bus.mem_we;
                end else if (r_addr !== mem_bus.mem_addr || r_strb !== mem_bus.mem_wstrb ||
                             r_wdata !== mem_bus.mem_wdata || r_we !== mem_bus.mem_we)
                    req_stable = 0;
                if (req_cnt == gnt_dly) begin
                    mem_bus.mem_gnt = 1; granted_at = k;
                end else if (noise) mem_bus.mem_rvalid = 1'($urandom);
                req_cnt++;
            end else begin
                if (mem_bus.mem_we !== 1'b0 || mem_bus.mem_wstrb !== 4'b0) quiet_ok = 0;
                if (granted_at >= 0 && !st && k == granted_at + 1 + rv_dly) begin
                    mem_bus.mem_rvalid = 1; mem_bus.mem_rdata = rword;
                end else if (noise && (st || granted_at < 0 || k > granted_at + 1 + rv_dly))
                    mem_bus.mem_rvalid = 1'($urandom);
            end
            #1;
            if (done === 1'b1) begin
                got_done = 1; done_k = k; flt = fault; cause = fault_cause; rd = rdata;
            end
        end
        @(posedge clk); #1;
        busy_after = busy;
        start = 0; mem_bus.mem_gnt = 0; mem_bus.mem_rvalid = 0;
    endtask

    // Shared result variables for the test tasks
    int d_k, r_cnt;
    bit d_flt, r_we, r_stable, q_ok, b_ok, b_after;
    bit [1:0] d_cause;
    bit [31:0] d_rd, r_addr, r_wdata;
    bit [3:0] r_strb;

    task automatic test_reset();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
        checks++; if (fault !== 1'b0 || fault_cause !== 2'b00) begin
            errors++; $display("FAIL reset_fault got %b/%b want 0/00", fault, fault_cause); end
        checks++; if (rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", rdata); end
        checks++; if (mem_bus.mem_req !== 1'b0 || mem_bus.mem_we !== 1'b0) begin
            errors++; $display("FAIL reset_req got %b/%b want 0/0", mem_bus.mem_req, mem_bus.mem_we); end
        checks++; if (mem_bus.mem_addr !== 32'h0 || mem_bus.mem_wdata !== 32'h0 ||
                      mem_bus.mem_wstrb !== 4'h0) begin
            errors++; $display("FAIL reset_bus got %h/%h/%b want 0/0/0", mem_bus.mem_addr,
                               mem_bus.mem_wdata, mem_bus.mem_wstrb); end
    endtask

    task automatic test_load_word();
        do_access(0, 3'b010, 32'h100, 32'h0, 0, 0, 32'hDEADBEEF, 0, d_k, d_flt, d_cause, d_rd,
                  r_cnt, r_addr, r_strb, r_wdata, r_we, r_stable, q_ok, b_ok, b_after);
        last_rdata = 32'hDEADBEEF;
        checks++; if (r_addr !== 32'h100) begin errors++; $display("FAIL lw_addr got %h want 100", r_addr); end
        checks++; if (d_k !== 3) begin errors++; $display("FAIL lw_latency got %0d want 3", d_k); end
        checks++; if (d_rd !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rdata got %h want deadbeef", d_rd); end
        checks++; if (d_flt !== 1'b0 || r_we !== 1'b0) begin
            errors++; $display("FAIL lw_flags fault=%b we=%b want 0/0", d_flt, r_we); end
        checks++; if (!b_ok || b_after !== 1'b0) begin
            errors++; $display("FAIL lw_busy ok=%b after=%b want 1/0", b_ok, b_after); end
    endtask

    task automatic test_load_byte();
        do_access(0, 3'b000, 32'h103, 32'h0, 0, 0, 32'h80FF0000, 0, d_k, d_flt, d_cause, d_rd,
                  r_cnt, r_addr, r_strb, r_wdata, r_we, r_stable, q_ok, b_ok, b_after);
        checks++; if (d_rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext got %h want ffffff80", d_rd); end
        do_access(0, 3'b100, 32'h103, 32'h0, 0, 0, 32'h80FF0000, 0, d_k, d_flt, d_cause, d_rd,
                  r_cnt, r_addr, r_strb, r_wdata, r_we, r_stable, q_ok, b_ok, b_after);
        last_rdata = 32'h00000080;
        checks++; if (d_rd !== 32'h00000080) begin errors++; $display("FAIL lbu_zext got %h want 00000080", d_rd); end
        checks++; if (rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_hold got %h want 00000080", rdata); end
    endtask

    task automatic test_store_half();
        do_access(1, 3'b001, 32'h202, 32'h1234ABCD, 0, 0, 32'h0, 0, d_k, d_flt, d_cause, d_rd,
                  r_cnt, r_addr, r_strb, r_wdata, r_we, r_stable, q_ok, b_ok, b_after);
        checks++; if (r_we !== 1'b1 || r_addr !== 32'h200) begin
            errors++; $display("FAIL sh_we_addr got %b/%h want 1/200", r_we, r_addr); end
        checks++; if (r_strb !== 4'b1100) begin errors++; $display("FAIL sh_strb got %b want 1100", r_strb); end
        checks++; if (r_wdata !== 32'hABCDABCD) begin errors++; $display("FAIL sh_wdata got %h want abcdabcd", r_wdata); end
        checks++; if (d_k !== 2 || d_flt !== 1'b0) begin
            errors++; $display("FAIL sh_done got k=%0d f=%b want 2/0", d_k, d_flt); end
        checks++; if (d_rd !== last_rdata) begin errors++; $display("FAIL sh_rdata_kept got %h want %h", d_rd, last_rdata); end
        checks++; if (!q_ok) begin errors++; $display("FAIL sh_quiet got %b want 1", q_ok); end
    endtask

    task automatic test_faults();
        do_access(0, 3'b010, 32'h101, 32'h0, 0, 0, 32'h0, 0, d_k, d_flt, d_cause, d_rd,
                  r_cnt, r_addr, r_strb, r_wdata, r_we, r_stable, q_ok, b_ok, b_after);
        checks++; if (r_cnt !== 0 || d_k !== 1) begin
            errors++; $display("FAIL misalign_noreq got req=%0d k=%0d want 0/1", r_cnt, d_k); end
        checks++; if (d_flt !== 1'b1 || d_cause !== 2'b01) begin
            errors++; $display("FAIL misalign_cause got %b/%b want 1/01", d_flt, d_cause); end
        do_access(1, 3'b100, 32'h0, 32'h0, 0, 0, 32'h0, 0, d_k, d_flt, d_cause, d_rd,
                  r_cnt, r_addr, r_strb, r_wdata, r_we, r_stable, q_ok, b_ok, b_after);
        checks++; if (d_flt !== 1'b1 || d_cause !== 2'b10 || r_cnt !== 0) begin
            errors++; $display("FAIL illegal_cause got %b/%b req=%0d want 1/10/0", d_flt, d_cause, r_cnt); end
        do_access(1, 3'b111, 32'h3, 32'h0, 0, 0, 32'h0, 0, d_k, d_flt, d_cause, d_rd,
                  r_cnt, r_addr, r_strb, r_wdata, r_we, r_stable, q_ok, b_ok, b_after);
        checks++; if (d_cause !== 2'b10) begin errors++; $display("FAIL illegal_priority got %b want 10", d_cause); end
        checks++; if (d_rd !== last_rdata) begin errors++; $display("FAIL fault_rdata_kept got %h want %h", d_rd, last_rdata); end
    endtask

    task automatic test_gnt_stall();
        do_access(1, 3'b010, 32'h44, 32'hCAFEF00D, 5, 0, 32'h0, 1, d_k, d_flt, d_cause, d_rd,
                  r_cnt, r_addr, r_strb, r_wdata, r_we, r_stable, q_ok, b_ok, b_after);
        checks++; if (!r_stable || r_cnt !== 6) begin
            errors++; $display("FAIL stall_req got stable=%b cycles=%0d want 1/6", r_stable, r_cnt); end
        checks++; if (r_wdata !== 32'hCAFEF00D || r_strb !== 4'hF || r_addr !== 32'h44) begin
            errors++; $display("FAIL stall_bus got %h/%b/%h want cafef00d/1111/44", r_wdata, r_strb, r_addr); end
        checks++; if (d_k !== 7 || d_flt !== 1'b0) begin
            errors++; $display("FAIL stall_done got k=%0d f=%b want 7/0", d_k, d_flt); end
        checks++; if (!b_ok || b_after !== 1'b0) begin
            errors++; $display("FAIL stall_busy ok=%b after=%b want 1/0", b_ok, b_after); end
    endtask

    task automatic test_back_to_back();
        do_access(0, 3'b001, 32'h10, 32'h0, 0, 0, 32'h8001_7FFF, 0, d_k, d_flt, d_cause, d_rd,
                  r_cnt, r_addr, r_strb, r_wdata, r_we, r_stable, q_ok, b_ok, b_after);
        checks++; if (d_k !== 3 || d_rd !== 32'h00007FFF) begin
            errors++; $display("FAIL b2b_first got k=%0d rd=%h want 3/00007fff", d_k, d_rd); end
        do_access(0, 3'b001, 32'h12, 32'h0, 1, 2, 32'h8001_7FFF, 0, d_k, d_flt, d_cause, d_rd,
                  r_cnt, r_addr, r_strb, r_wdata, r_we, r_stable, q_ok, b_ok, b_after);
        last_rdata = 32'hFFFF8001;
        checks++; if (d_k !== 6 || d_rd !== 32'hFFFF8001) begin
            errors++; $display("FAIL b2b_second got k=%0d rd=%h want 6/ffff8001", d_k, d_rd); end
    endtask

    task automatic test_random();
        bit st; bit [2:0] f3; bit [31:0] a, wd, rw, exp_rd;
        bit [1:0] exp_c; int gd, rv, exp_k;
        for (int n = 0; n < 40; n++) begin
            st = 1'($urandom); f3 = 3'($urandom); a = $urandom; wd = $urandom; rw = $urandom;
            gd = int'($urandom_range(3, 0)); rv = int'($urandom_range(2, 0));
            do_access(st, f3, a, wd, gd, rv, rw, 1'($urandom), d_k, d_flt, d_cause, d_rd,
                      r_cnt, r_addr, r_strb, r_wdata, r_we, r_stable, q_ok, b_ok, b_after);
            exp_c = m_cause(st, f3, a);
            exp_k = (exp_c != 0) ? 1 : (st ? gd + 2 : gd + rv + 3);
            exp_rd = (exp_c == 0 && !st) ? m_load(f3, a, rw) : last_rdata;
            last_rdata = exp_rd;
            checks++; if (d_k !== exp_k || d_flt !== (exp_c != 0)) begin
                errors++; $display("FAIL rnd_done n=%0d got k=%0d f=%b want %0d/%b", n, d_k, d_flt,
                                   exp_k, exp_c != 0); end
            checks++; if (d_cause !== exp_c) begin
                errors++; $display("FAIL rnd_cause n=%0d got %b want %b", n, d_cause, exp_c); end
            checks++; if (d_rd !== exp_rd) begin
                errors++; $display("FAIL rnd_rdata n=%0d got %h want %h", n, d_rd, exp_rd); end
            checks++; if (!r_stable || !q_ok || !b_ok || b_after !== 1'b0) begin
                errors++; $display("FAIL rnd_protocol n=%0d got %b%b%b%b want 1110", n, r_stable,
                                   q_ok, b_ok, b_after); end
            if (exp_c == 0) begin
                checks++; if (r_addr !== {a[31:2], 2'b00} || r_we !== st) begin
                    errors++; $display("FAIL rnd_addr n=%0d got %h/%b want %h/%b", n, r_addr, r_we,
                                       {a[31:2], 2'b00}, st); end
                if (st) begin
                    checks++; if (r_strb !== m_strb(f3, a) || r_wdata !== m_wdata(f3, wd)) begin
                        errors++; $display("FAIL rnd_store n=%0d got %b/%h want %b/%h", n, r_strb,
                                           r_wdata, m_strb(f3, a), m_wdata(f3, wd)); end
                end
            end else begin
                checks++; if (r_cnt !== 0) begin
                    errors++; $display("FAIL rnd_fault_noreq n=%0d got %0d want 0", n, r_cnt); end
            end
        end
    endtask

    task automatic test_reset_mid();
        // Reset during REQ
        start = 1; is_store = 1; funct3 = 3'b010; addr = 32'h80; wdata = 32'h1;
        @(posedge clk); #1; start = 0;
        checks++; if (mem_bus.mem_req !== 1'b1) begin errors++; $display("FAIL rstreq_pre got %b want 1", mem_bus.mem_req); end
        rst = 1; #1;
        checks++; if (mem_bus.mem_req !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL rstreq_drop got %b/%b want 0/0", mem_bus.mem_req, busy); end
        @(posedge clk); #1; rst = 0;
        // Reset during WAIT, followed by a stale rvalid
        start = 1; is_store = 0; funct3 = 3'b010; addr = 32'h40;
        @(posedge clk); #1; start = 0; mem_bus.mem_gnt = 1;
        @(posedge clk); #1; mem_bus.mem_gnt = 0;
        checks++; if (busy !== 1'b1 || mem_bus.mem_req !== 1'b0) begin
            errors++; $display("FAIL rstwait_pre got %b/%b want 1/0", busy, mem_bus.mem_req); end
        rst = 1; #1;
        checks++; if (busy !== 1'b0 || done !== 1'b0 || mem_bus.mem_req !== 1'b0) begin
            errors++; $display("FAIL rstwait_drop got %b%b%b want 000", busy, done, mem_bus.mem_req); end
        @(posedge clk); #1; rst = 0; mem_bus.mem_rvalid = 1; mem_bus.mem_rdata = 32'h55;
        #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rstwait_nodone got %b want 0", done); end
        @(posedge clk); #1; mem_bus.mem_rvalid = 0;
        last_rdata = 32'h0;
        checks++; if (rdata !== 32'h0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL rstwait_late got %h/%b/%b want 0/0/0", rdata, busy, done); end
    endtask

`ifdef LSU_TIMEOUT_EN
    task automatic test_timeout();
        do_access(1, 3'b010, 32'h300, 32'h9, 100000, 0, 32'h0, 0, d_k, d_flt, d_cause, d_rd,
                  r_cnt, r_addr, r_strb, r_wdata, r_we, r_stable, q_ok, b_ok, b_after);
        checks++; if (d_flt !== 1'b1 || d_cause !== 2'b11) begin
            errors++; $display("FAIL timeout_cause got %b/%b want 1/11", d_flt, d_cause); end
        checks++; if (d_k < int'(TO) || d_k > int'(TO) + 3) begin
            errors++; $display("FAIL timeout_latency got %0d want %0d..%0d", d_k, TO, TO + 3); end
    endtask
`endif

    initial begin
        rst = 1; start = 0; is_store = 0; funct3 = 0; addr = 0; wdata = 0;
        mem_bus.mem_gnt = 0; mem_bus.mem_rvalid = 0; mem_bus.mem_rdata = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        rst = 0;
        @(posedge clk); #1;
        test_load_word();
        test_load_byte();
        test_store_half();
        test_faults();
        test_gnt_stall();
        test_back_to_back();
        test_random();
        test_reset_mid();
`ifdef LSU_TIMEOUT_EN
        test_timeout();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
